// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the cache arbiter / physical memory environment and the
// cacheline adaptor. The adaptor takes the slave view; the surrounding system
// (arbiter on the line side, memory on the burst side) takes the master view.
interface cacheline_adaptor_if;
  // Line side (cache arbiter)
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  // Burst side (physical memory)
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  line_read, line_write, line_address, line_wdata, burst_i, resp_i,
    output line_rdata, line_resp, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_read, line_write, line_address, line_wdata, burst_i, resp_i,
    input  line_rdata, line_resp, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: converts one 256-bit line read/write from the cache
// arbiter into four 64-bit beats to physical memory, low beat first.
// All outputs are registered and derived from the next-state values, so they
// behave as Moore outputs of the state they accompany.
module cacheline_adaptor (
  input  logic                  clk,
  input  logic                  rst,
  cacheline_adaptor_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_r, state_s;
  logic [1:0]   cnt_r, cnt_s;
  logic [31:0]  addr_r, addr_s;
  logic [255:0] buf_r, buf_s;
  logic [63:0]  wbeat_s;

  // Beat presented on the write bus for the upcoming cycle.
  assign wbeat_s = buf_s[{cnt_s, 6'd0} +: 64];

  // Next-state, beat counter, address and line buffer update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    buf_s   = buf_r;
    case (state_r)
      IDLE: begin
        // Read takes priority; a simultaneous write is dropped entirely.
        if (bus.line_read) begin
          addr_s  = {bus.line_address[31:5], 5'd0};
          cnt_s   = 2'd0;
          state_s = READ;
        end else if (bus.line_write) begin
          addr_s  = {bus.line_address[31:5], 5'd0};
          buf_s   = bus.line_wdata;
          cnt_s   = 2'd0;
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          buf_s[{cnt_r, 6'd0} +: 64] = bus.burst_i;
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_s = DONE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = READ;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_s = DONE;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State registers and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      cnt_r          <= 2'd0;
      addr_r         <= 32'd0;
      buf_r          <= 256'd0;
      bus.read_o     <= 1'b0;
      bus.write_o    <= 1'b0;
      bus.address_o  <= 32'd0;
      bus.burst_o    <= 64'd0;
      bus.line_resp  <= 1'b0;
      bus.line_rdata <= 256'd0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      addr_r         <= addr_s;
      buf_r          <= buf_s;
      bus.read_o     <= (state_s == READ);
      bus.write_o    <= (state_s == WRITE);
      bus.address_o  <= ((state_s == READ) || (state_s == WRITE)) ? addr_s : 32'd0;
      bus.burst_o    <= (state_s == WRITE) ? wbeat_s : 64'd0;
      bus.line_resp  <= (state_s == DONE);
      bus.line_rdata <= buf_s;
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. Transactions are modelled at the
// transaction level: beats acknowledged by memory are collected in a queue and
// the expected line is their concatenation; handshake outputs are checked
// against what each phase of a transaction must look like.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [255:0] model_rdata;
  bit           rdata_known;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_read_o"},    256'(bus.read_o),    256'd0);
    check({tag, "_write_o"},   256'(bus.write_o),   256'd0);
    check({tag, "_address_o"}, 256'(bus.address_o), 256'd0);
    check({tag, "_burst_o"},   256'(bus.burst_o),   256'd0);
    check({tag, "_line_resp"}, 256'(bus.line_resp), 256'd0);
  endtask

  // One IDLE cycle with no request and a random stray acknowledge.
  task automatic idle_cycle();
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    bus.resp_i     = 1'($urandom_range(0, 1));
    bus.burst_i    = {$urandom, $urandom};
    step();
    check_quiet("idle");
    if (rdata_known) check("idle_rdata", bus.line_rdata, model_rdata);
    bus.resp_i = 1'b0;
  endtask

  // Line read; fixed=1 gives the zero-wait 11..44 pattern, both=1 also raises
  // line_write, abort_at>0 applies reset after that many acknowledged beats.
  task automatic do_read(input logic [31:0] addr, input bit fixed, input bit both, input int abort_at);
    logic [63:0]  beats[$];
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    int           acks;
    int           cyc;
    bit           ack;
    exp_addr = {addr[31:5], 5'd0};
    acks = 0;
    cyc  = 0;
    bus.line_read    = 1'b1;
    bus.line_write   = both;
    bus.line_address = addr;
    bus.line_wdata   = {8{$urandom}};
    step();
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    while (acks < 4 && cyc < 64) begin
      check("rd_read_o",    256'(bus.read_o),    256'd1);
      check("rd_write_o",   256'(bus.write_o),   256'd0);
      check("rd_address_o", 256'(bus.address_o), 256'(exp_addr));
      check("rd_line_resp", 256'(bus.line_resp), 256'd0);
      if (cyc == 0 && rdata_known) check("rd_rdata_hold", bus.line_rdata, model_rdata);
      if (abort_at > 0 && acks == abort_at) begin
        rst        = 1'b1;
        bus.resp_i = 1'b1;
        step();
        rst        = 1'b0;
        bus.resp_i = 1'b0;
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        check_quiet("rst_abort");
        check("rst_abort_rdata", bus.line_rdata, 256'd0);
        model_rdata = 256'd0;
        rdata_known = 1'b1;
        return;
      end
      ack = fixed ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.resp_i  = ack;
      bus.burst_i = fixed ? {16{4'(acks + 1)}} : {$urandom, $urandom};
      if (ack) beats.push_back(bus.burst_i);
      bus.line_read    = 1'($urandom_range(0, 1));
      bus.line_write   = 1'($urandom_range(0, 1));
      bus.line_address = $urandom;
      step();
      cyc++;
      if (ack) acks++;
    end
    check("rd_beat_count", 256'(acks), 256'd4);
    if (acks == 4) begin
      exp_line = {beats[3], beats[2], beats[1], beats[0]};
      check("rd_done_resp",  256'(bus.line_resp), 256'd1);
      check("rd_done_read",  256'(bus.read_o),    256'd0);
      check("rd_done_write", 256'(bus.write_o),   256'd0);
      check("rd_done_addr",  256'(bus.address_o), 256'd0);
      check("rd_done_rdata", bus.line_rdata,      exp_line);
      model_rdata = exp_line;
      rdata_known = 1'b1;
      bus.resp_i  = 1'($urandom_range(0, 1));
      bus.burst_i = {$urandom, $urandom};
      step();
      check_quiet("rd_after");
      check("rd_after_rdata", bus.line_rdata, model_rdata);
      bus.resp_i = 1'b0;
    end
  endtask

  // Line write; pat=1 uses the ack pattern 1,0,0,1,1,0,1.
  task automatic do_write(input logic [31:0] addr, input bit pat);
    int           ack_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [255:0] wdata;
    logic [31:0]  exp_addr;
    int           acks;
    int           cyc;
    bit           ack;
    exp_addr = {addr[31:5], 5'd0};
    wdata    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    acks = 0;
    cyc  = 0;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b1;
    bus.line_address = addr;
    bus.line_wdata   = wdata;
    step();
    bus.line_write = 1'b0;
    while (acks < 4 && cyc < 64) begin
      check("wr_write_o",   256'(bus.write_o),   256'd1);
      check("wr_read_o",    256'(bus.read_o),    256'd0);
      check("wr_address_o", 256'(bus.address_o), 256'(exp_addr));
      check("wr_line_resp", 256'(bus.line_resp), 256'd0);
      check("wr_burst_o",   256'(bus.burst_o),   256'(wdata[64*acks +: 64]));
      ack = pat ? (ack_pat[cyc] != 0) : ($urandom_range(0, 2) != 0);
      bus.resp_i       = ack;
      bus.line_read    = 1'($urandom_range(0, 1));
      bus.line_write   = 1'($urandom_range(0, 1));
      bus.line_wdata   = {8{$urandom}};
      bus.line_address = $urandom;
      step();
      cyc++;
      if (ack) acks++;
    end
    check("wr_beat_count", 256'(acks), 256'd4);
    check("wr_done_resp",  256'(bus.line_resp), 256'd1);
    check("wr_done_write", 256'(bus.write_o),   256'd0);
    check("wr_done_burst", 256'(bus.burst_o),   256'd0);
    check("wr_done_addr",  256'(bus.address_o), 256'd0);
    rdata_known = 1'b0;
    bus.resp_i  = 1'($urandom_range(0, 1));
    step();
    check_quiet("wr_after");
    bus.resp_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_address = 32'd0;
    bus.line_wdata   = 256'd0;
    bus.burst_i      = 64'd0;
    bus.resp_i       = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_quiet("reset");
    check("reset_rdata", bus.line_rdata, 256'd0);
    model_rdata = 256'd0;
    rdata_known = 1'b1;

    // Directed zero-wait read of 0x1234.
    do_read(32'h0000_1234, 1'b1, 1'b0, 0);
    check("rd_directed_line", model_rdata,
          {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    idle_cycle();
    // Write with gaps in the acknowledge stream.
    do_write(32'hABCD_EF17, 1'b1);
    idle_cycle();
    // Establish a known line, then read and write requested together.
    do_read($urandom, 1'b0, 1'b0, 0);
    do_read($urandom, 1'b0, 1'b1, 0);
    idle_cycle();
    // Reset after two beats, then a clean read.
    do_read($urandom, 1'b0, 1'b0, 2);
    idle_cycle();
    do_read($urandom, 1'b0, 1'b0, 0);
    // Back-to-back reads.
    do_read($urandom, 1'b0, 1'b0, 0);

    // Random mix of transactions.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       do_write($urandom, 1'b0);
        1:       idle_cycle();
        2:       do_read($urandom, 1'b0, 1'($urandom_range(0, 1)), 0);
        default: do_read($urandom, 1'b0, 1'b0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
